// File: rtl/da_mac_sequencer_if.sv
// Sample/weight request, partial-sum table link and filter-output handshake
// of the DA sequencer, seen from the environment (master) and the sequencer (slave).
interface da_mac_sequencer_if #(
  parameter int XW = 8,
  parameter int WW = 8,
  parameter int TW = 10,
  parameter int YW = 18
) ();
  logic            in_valid;
  logic            in_ready;
  logic [XW-1:0]   x_in;
  logic [4*WW-1:0] w_in;
  logic [XW-1:0]   x_n;
  logic [XW-1:0]   x_n1;
  logic [XW-1:0]   x_n2;
  logic            tstep;
  logic [16*TW-1:0] tbl;
  logic [3:0]      tbl_addr;
  logic [YW-1:0]   y;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  in_valid, x_in, w_in, tbl, out_ready,
    output in_ready, x_n, x_n1, x_n2, tstep, tbl_addr, y, out_valid
  );

  modport master (
    output in_valid, x_in, w_in, tbl, out_ready,
    input  in_ready, x_n, x_n1, x_n2, tstep, tbl_addr, y, out_valid
  );
endinterface

// File: rtl/da_mac_sequencer.sv
// Bit-serial DA sequencer for a 4-tap filter: accept -> y valid after WW cycles;
// a new sample is accepted only in IDLE, and y is held in DONE until out_ready.
module da_mac_sequencer #(
  parameter int XW = 8,
  parameter int WW = 8,
  parameter int TW = 10,
  parameter int YW = 18
) (
  input logic               clk,
  input logic               r,
  da_mac_sequencer_if.slave bus
);
  localparam int KW = (WW > 1) ? $clog2(WW) : 1;
  localparam logic [KW-1:0] K_MSB = KW'(WW - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t               state;
  logic [XW-1:0]        x0_q, x1_q, x2_q;
  logic [WW-1:0]        w_q [4];
  logic [KW-1:0]        k;
  logic [3:0]           addr;
  logic signed [YW-1:0] acc;
  logic signed [YW-1:0] y_q;
  logic                 out_vld;

  logic                 accept;
  logic [KW-1:0]        k_dn;
  logic [WW-1:0]        w_in_arr [4];
  logic [TW-1:0]        tbl_arr [16];
  logic [TW-1:0]        t_raw;
  logic signed [YW-1:0] t_ext;
  logic signed [YW-1:0] acc_nxt;

  for (genvar a = 0; a < 16; a++) begin : g_tbl
    assign tbl_arr[a] = bus.tbl[a*TW +: TW];
  end

  for (genvar i = 0; i < 4; i++) begin : g_win
    assign w_in_arr[i] = bus.w_in[i*WW +: WW];
  end

  function automatic logic [3:0] slice(input logic [KW-1:0] b);
    return {w_q[3][b], w_q[2][b], w_q[1][b], w_q[0][b]};
  endfunction

  assign bus.in_ready = (state == IDLE) & r;
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.tstep    = accept;
  assign k_dn         = k - 1'b1;

  // Weight MSB carries negative significance, so the first slice is subtracted.
  assign t_raw   = tbl_arr[addr];
  assign t_ext   = {{(YW-TW){t_raw[TW-1]}}, t_raw};
  assign acc_nxt = (k == K_MSB) ? -t_ext : (acc <<< 1) + t_ext;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state   <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      for (int i = 0; i < 4; i++) w_q[i] <= '0;
      k       <= '0;
      addr    <= '0;
      acc     <= '0;
      y_q     <= '0;
      out_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x0_q  <= bus.x_in;
            x1_q  <= x0_q;
            x2_q  <= x1_q;
            w_q   <= w_in_arr;
            acc   <= '0;
            k     <= K_MSB;
            addr  <= {w_in_arr[3][WW-1], w_in_arr[2][WW-1],
                      w_in_arr[1][WW-1], w_in_arr[0][WW-1]};
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc <= acc_nxt;
          if (k == '0) begin
            y_q     <= acc_nxt;
            out_vld <= 1'b1;
            addr    <= '0;
            state   <= DONE;
          end else begin
            k    <= k_dn;
            addr <= slice(k_dn);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_n       = x0_q;
  assign bus.x_n1      = x1_q;
  assign bus.x_n2      = x2_q;
  assign bus.tbl_addr  = addr;
  assign bus.y         = y_q;
  assign bus.out_valid = out_vld;
endmodule

// File: tb/tb_da_mac_sequencer.sv
// Bench for da_mac_sequencer: registered DA table model, transaction-level
// reference (dot product + fixed latency), directed cases and a random run.
module tb_da_mac_sequencer;
  localparam int XW = 8;
  localparam int WW = 8;
  localparam int TW = 10;
  localparam int YW = 18;

  logic clk = 1'b0;
  logic r   = 1'b1;

  da_mac_sequencer_if #(.XW(XW), .WW(WW), .TW(TW), .YW(YW)) bus ();

  da_mac_sequencer #(.XW(XW), .WW(WW), .TW(TW), .YW(YW)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // External partial-sum table: its own delay line x(n)..x(n-3), stepped by tstep.
  int td [4];

  always @(posedge clk or negedge r) begin
    if (!r) begin
      for (int i = 0; i < 4; i++) td[i] <= 0;
    end else if (bus.tstep) begin
      td[0] <= int'($signed(bus.x_in));
      td[1] <= td[0];
      td[2] <= td[1];
      td[3] <= td[2];
    end
  end

  function automatic logic [16*TW-1:0] build_tbl(input int d0, input int d1,
                                                  input int d2, input int d3);
    logic [16*TW-1:0] v;
    logic [TW-1:0]    e;
    int               s;
    v = '0;
    for (int a = 0; a < 16; a++) begin
      s = 0;
      if (a[0]) s += d0;
      if (a[1]) s += d1;
      if (a[2]) s += d2;
      if (a[3]) s += d3;
      e = TW'(s);
      v = v | ((16*TW)'(e) << (a*TW));
    end
    return v;
  endfunction

  assign bus.tbl = build_tbl(td[0], td[1], td[2], td[3]);

  // Reference model: y = sum w_i * x(n-i); y appears WW edges after accept.
  function automatic int dot(input logic [4*WW-1:0] w, input int a0, input int a1,
                             input int a2, input int a3);
    int            xs [4];
    int            s;
    logic [WW-1:0] wb;
    xs = '{a0, a1, a2, a3};
    s  = 0;
    for (int i = 0; i < 4; i++) begin
      wb = WW'(w >> (i*WW));
      s += int'($signed(wb)) * xs[i];
    end
    return s;
  endfunction

  function automatic int exp_addr(input logic [4*WW-1:0] w, input int b);
    int v;
    v = 0;
    for (int i = 0; i < 4; i++)
      if (((w >> (i*WW + b)) & 1) != 0) v |= (1 << i);
    return v;
  endfunction

  bit              m_idle;
  bit              m_ov;
  int              m_cnt;
  int              m_y;
  int              pend;
  int              hist [4];
  logic [4*WW-1:0] m_w;

  always @(posedge clk or negedge r) begin
    if (!r) begin
      m_idle <= 1'b1;
      m_ov   <= 1'b0;
      m_cnt  <= 0;
      m_y    <= 0;
      pend   <= 0;
      m_w    <= '0;
      for (int i = 0; i < 4; i++) hist[i] <= 0;
    end else begin
      if (m_ov && bus.out_ready) begin
        m_ov   <= 1'b0;
        m_idle <= 1'b1;
      end
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_ov <= 1'b1;
          m_y  <= pend;
        end
      end
      if (m_idle && bus.in_valid) begin
        hist[0] <= int'($signed(bus.x_in));
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        hist[3] <= hist[2];
        m_w     <= bus.w_in;
        pend    <= dot(bus.w_in, int'($signed(bus.x_in)), hist[0], hist[1], hist[2]);
        m_cnt   <= WW;
        m_idle  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!r) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_tstep", bus.tstep, 0);
      chk("rst_y", bus.y, 0);
      chk("rst_x_n", bus.x_n, 0);
      chk("rst_tbl_addr", bus.tbl_addr, 0);
    end else begin
      chk("in_ready", bus.in_ready, m_idle);
      chk("tstep", bus.tstep, bus.in_valid & m_idle);
      chk("out_valid", bus.out_valid, m_ov);
      if (m_ov) chk("y", $signed(bus.y), m_y);
      chk("x_n", $signed(bus.x_n), hist[0]);
      chk("x_n1", $signed(bus.x_n1), hist[1]);
      chk("x_n2", $signed(bus.x_n2), hist[2]);
      if (m_cnt > 0) chk("tbl_addr", bus.tbl_addr, exp_addr(m_w, m_cnt - 1));
    end
  end

  int outs [$];
  int tstep_cnt = 0;

  always @(negedge clk) begin
    if (r && bus.out_valid && bus.out_ready) outs.push_back(int'($signed(bus.y)));
    if (r && bus.tstep) tstep_cnt++;
  end

  task automatic reset_dut();
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.w_in     = '0;
    r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    r = 1'b1;
    outs.delete();
    tstep_cnt = 0;
  endtask

  task automatic do_txn(input int x, input logic [4*WW-1:0] w);
    bit got;
    got          = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_in     = XW'(x);
    bus.w_in     = w;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = bus.tstep;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("accept_seen", got, 1);
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (outs.size() < n && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("out_count", outs.size(), n);
  endtask

  bit rnd_done = 1'b0;

  initial begin
    int          lat;
    int          addrs [$];
    int          x;
    logic [7:0]  xb;

    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.w_in      = '0;
    bus.out_ready = 1'b1;
    #1 r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", bus.y, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    r = 1'b1;

    // Four samples through fixed weights w3..w0 = 4,3,2,1.
    reset_dut();
    foreach (outs[i]) outs.delete(i);
    do_txn(10, {8'd4, 8'd3, 8'd2, 8'd1});
    do_txn(20, {8'd4, 8'd3, 8'd2, 8'd1});
    do_txn(30, {8'd4, 8'd3, 8'd2, 8'd1});
    do_txn(40, {8'd4, 8'd3, 8'd2, 8'd1});
    wait_outs(4);
    chk("fir_y0", outs[0], 10);
    chk("fir_y1", outs[1], 40);
    chk("fir_y2", outs[2], 100);
    chk("fir_y3", outs[3], 200);
    chk("fir_tsteps", tstep_cnt, 4);

    // Latency and bit-slice walk for a single tap.
    reset_dut();
    do_txn(5, 32'h0000_0001);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      addrs.push_back(int'(bus.tbl_addr));
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 8);
    chk("addr_count", addrs.size(), 8);
    for (int i = 0; i < 7; i++) chk("addr_hi_slices", addrs[i], 0);
    chk("addr_lsb_slice", addrs[7], 1);
    wait_outs(1);
    chk("single_y", outs[0], 5);

    // Negative extremes.
    reset_dut();
    for (int i = 0; i < 4; i++) do_txn(-128, 32'h8080_8080);
    wait_outs(4);
    chk("neg_y3", outs[3], 65536);
    reset_dut();
    do_txn(127, 32'h0000_0080);
    wait_outs(1);
    chk("neg_w0_y", outs[0], -16256);

    // Backpressure in DONE with a pending sample.
    reset_dut();
    bus.out_ready = 1'b0;
    do_txn(3, 32'h0000_0001);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b1;
    bus.x_in     = XW'(50);
    bus.w_in     = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_y_hold", $signed(bus.y), 3);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_tstep", bus.tstep, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", bus.out_valid, 0);
    chk("bp_release_in_ready", bus.in_ready, 1);
    chk("bp_release_tstep", bus.tstep, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_accept_x_n", $signed(bus.x_n), 50);
    wait_outs(2);
    chk("bp_y0", outs[0], 3);
    chk("bp_y1", outs[1], 50);

    // Reset while the bit counter is at k=3.
    reset_dut();
    do_txn(9, 32'h0000_0001);
    wait_outs(1);
    do_txn(100, 32'h0101_0101);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    r = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_y", bus.y, 0);
    chk("midrst_x_n", bus.x_n, 0);
    chk("midrst_x_n1", bus.x_n1, 0);
    chk("midrst_tbl_addr", bus.tbl_addr, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    r = 1'b1;
    outs.delete();
    do_txn(7, 32'h0000_0002);
    wait_outs(1);
    chk("midrst_y_after", outs[0], 14);
    chk("midrst_x_n_after", $signed(bus.x_n), 7);
    chk("midrst_x_n1_after", $signed(bus.x_n1), 0);

    // Weight bus churning after acceptance.
    reset_dut();
    do_txn(11, 32'h0000_0003);
    for (int i = 0; i < 40 && outs.size() < 1; i++) begin
      bus.w_in = $urandom;
      @(posedge clk);
      #1;
    end
    chk("wtoggle_y", outs.size() > 0 ? outs[0] : 0, 33);

    // Random traffic with random backpressure.
    reset_dut();
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          xb = 8'($urandom);
          x  = int'($signed(xb));
          do_txn(x, $urandom);
          repeat ($urandom_range(0, 3)) begin
            bus.w_in = $urandom;
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_outs(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
